// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter
//
// Shares a single-ported CacheMemory between two requesters. Port 0 is
// instruction fetch and port 1 is data load/store. The arbiter takes one request
// at a time over a valid/ready handshake and chooses between the ports
// round-robin. It drives the cache for CACHE_LATENCY cycles, then returns a
// one-cycle response to the granted port.
//
// Parameters:
//   ADDR_WIDTH     request/cache address width
//   DATA_WIDTH     read/write data width
//   CACHE_LATENCY  cycles from cache address issue to valid cache_read_data (1..15)
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   req_valid[1:0]           per-port request valid
//   req_ready[1:0]           per-port accept pulse (IDLE only, at most one hot)
//   req_addr0/1              per-port address
//   req_write_enable[1:0]    per-port write flag (1 = store)
//   req_write_data0/1        per-port store data
//   resp_valid[1:0]          per-port one-cycle response pulse
//   resp_data                read data (0 for writes), held until the next capture
//   cache_addr               CacheMemory address
//   cache_write_enable       CacheMemory write enable
//   cache_write_data         CacheMemory write data
//   cache_read_data          CacheMemory read data
//
// Optional feature (macro CACHE_ARB_STATS_EN):
//   grant_count0/1           completed handshakes per port (saturating)
//   conflict_count           IDLE cycles with both ports valid (saturating)

module cache_port_arbiter #(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned CACHE_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr0,
    input  logic [ADDR_WIDTH-1:0] req_addr1,
    input  logic [1:0]            req_write_enable,
    input  logic [DATA_WIDTH-1:0] req_write_data0,
    input  logic [DATA_WIDTH-1:0] req_write_data1,
    output logic [1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic                  cache_write_enable,
    output logic [DATA_WIDTH-1:0] cache_write_data,
    input  logic [DATA_WIDTH-1:0] cache_read_data
`ifdef CACHE_ARB_STATS_EN
    ,
    output logic [31:0]           grant_count0,
    output logic [31:0]           grant_count1,
    output logic [31:0]           conflict_count
`endif
);

    localparam int unsigned CNT_WIDTH = 4;
    localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(CACHE_LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = 1;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StRespond
    } state_t;

    state_t               state_q, state_d;
    logic                 last_grant_q;  // also names the port of the transaction in flight
    logic                 is_write_q;    // write flag kept for the whole access
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 grant;
    logic                 handshake;

    // Single requester wins outright; on a conflict the port not served last wins.
    always_comb begin
        if (req_valid == 2'b11) begin
            grant = ~last_grant_q;
        end else begin
            grant = req_valid[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        handshake  = 1'b0;
        case (state_q)
            StIdle: begin
                // Ready is asserted only toward a valid port, so ready implies handshake.
                if ((req_valid != 2'b00) && !rst) begin
                    req_ready[grant] = 1'b1;
                    handshake        = 1'b1;
                    state_d          = StAccess;
                end
            end
            StAccess: begin
                if (cnt_q == '0) begin
                    state_d = StRespond;
                end
            end
            StRespond: begin
                resp_valid[last_grant_q] = 1'b1;
                state_d                  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q       <= 1'b1;
            is_write_q         <= 1'b0;
            cnt_q              <= '0;
            cache_addr         <= '0;
            cache_write_enable <= 1'b0;
            cache_write_data   <= '0;
            resp_data          <= '0;
        end else if (handshake) begin
            last_grant_q       <= grant;
            is_write_q         <= req_write_enable[grant];
            cnt_q              <= CNT_INIT;
            cache_addr         <= grant ? req_addr1 : req_addr0;
            cache_write_enable <= req_write_enable[grant];
            cache_write_data   <= grant ? req_write_data1 : req_write_data0;
        end else if (state_q == StAccess) begin
            // The write strobe lasts only the first access cycle.
            cache_write_enable <= 1'b0;
            if (cnt_q == '0) begin
                resp_data <= is_write_q ? '0 : cache_read_data;
            end else begin
                cnt_q <= cnt_q - CNT_ONE;
            end
        end
    end

`ifdef CACHE_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_count0   <= '0;
            grant_count1   <= '0;
            conflict_count <= '0;
        end else begin
            if (handshake && !grant && (grant_count0 != '1)) begin
                grant_count0 <= grant_count0 + 32'd1;
            end
            if (handshake && grant && (grant_count1 != '1)) begin
                grant_count1 <= grant_count1 + 32'd1;
            end
            if ((state_q == StIdle) && (req_valid == 2'b11) && (conflict_count != '1)) begin
                conflict_count <= conflict_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Testbench for cache_port_arbiter. A transaction-level reference model predicts
// grants, accept timing, cache strobes and responses; a small memory array plays
// the CacheMemory. Build with CACHE_ARB_STATS_EN to also check the statistics.

module tb_cache_port_arbiter;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned LAT = 3;

    logic          clk;
    logic          rst;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [AW-1:0] req_addr0, req_addr1;
    logic [1:0]    req_write_enable;
    logic [DW-1:0] req_write_data0, req_write_data1;
    logic [1:0]    resp_valid;
    logic [DW-1:0] resp_data;
    logic [AW-1:0] cache_addr;
    logic          cache_write_enable;
    logic [DW-1:0] cache_write_data;
    logic [DW-1:0] cache_read_data;
`ifdef CACHE_ARB_STATS_EN
    logic [31:0]   grant_count0, grant_count1, conflict_count;
`endif

    cache_port_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .CACHE_LATENCY(LAT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_addr0         (req_addr0),
        .req_addr1         (req_addr1),
        .req_write_enable  (req_write_enable),
        .req_write_data0   (req_write_data0),
        .req_write_data1   (req_write_data1),
        .resp_valid        (resp_valid),
        .resp_data         (resp_data),
        .cache_addr        (cache_addr),
        .cache_write_enable(cache_write_enable),
        .cache_write_data  (cache_write_data),
        .cache_read_data   (cache_read_data)
`ifdef CACHE_ARB_STATS_EN
        ,
        .grant_count0      (grant_count0),
        .grant_count1      (grant_count1),
        .conflict_count    (conflict_count)
`endif
    );

    // Stand-in CacheMemory: read data follows the held address.
    logic [DW-1:0] tb_mem [16];
    assign cache_read_data = tb_mem[cache_addr[3:0]];
    always @(posedge clk) begin
        if (cache_write_enable) tb_mem[cache_addr[3:0]] <= cache_write_data;
    end

    initial begin
        clk = 1'b0;
        #10;
        forever begin
            clk = 1'b1;
            #5;
            clk = 1'b0;
            #5;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state
    logic [DW-1:0] ref_mem [16];
    int            free_cyc;
    int            last_g;
    bit            have_txn;
    int            t_start, t_resp, t_port;
    logic [AW-1:0] t_addr;
    bit            t_we;
    logic [DW-1:0] t_wd, t_data, t_prior, held;
    int            st_g0, st_g1, st_conf;
    logic [1:0]    hs;

    // Requester drive state
    logic [1:0]    drv_valid, drv_we;
    logic [AW-1:0] drv_addr [2];
    logic [DW-1:0] drv_wd [2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        free_cyc = 0;
        last_g   = 1;
        have_txn = 0;
        held     = '0;
        st_g0    = 0;
        st_g1    = 0;
        st_conf  = 0;
        hs       = 2'b00;
    endtask

    // Called at the negedge of every simulated cycle.
    task automatic model_cycle();
        logic [1:0] v, exp_rdy, exp_rv;
        int g;
        bit idle;
        v       = req_valid;
        idle    = (cyc >= free_cyc);
        exp_rdy = 2'b00;
        g       = -1;
        if (idle && (v != 2'b00)) begin
            if (v == 2'b11) g = (last_g == 1) ? 0 : 1;
            else            g = v[0] ? 0 : 1;
            exp_rdy[g] = 1'b1;
        end
        check_eq("req_ready", req_ready, exp_rdy);
        hs = req_valid & req_ready;

        exp_rv = 2'b00;
        if (have_txn && (cyc == t_resp)) begin
            exp_rv[t_port] = 1'b1;
            held           = t_data;
        end
        check_eq("resp_valid", resp_valid, exp_rv);
        check_eq("resp_data", resp_data, held);
        check_eq("cache_we", cache_write_enable, (have_txn && t_we && (cyc == t_start)));
        if (have_txn && (cyc >= t_start) && (cyc < t_resp)) begin
            check_eq("cache_addr", cache_addr, t_addr);
            check_eq("cache_wdata", cache_write_data, t_wd);
        end

        if (idle && (v == 2'b11)) st_conf++;
        if (g >= 0) begin
            have_txn = 1;
            t_port   = g;
            t_start  = cyc + 1;
            t_resp   = cyc + LAT + 1;
            free_cyc = cyc + LAT + 2;
            last_g   = g;
            t_addr   = drv_addr[g];
            t_we     = drv_we[g];
            t_wd     = drv_wd[g];
            t_prior  = ref_mem[t_addr[3:0]];
            t_data   = t_we ? '0 : ref_mem[t_addr[3:0]];
            if (t_we) ref_mem[t_addr[3:0]] = t_wd;
            if (g == 0) st_g0++;
            else        st_g1++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        req_valid        = drv_valid;
        req_write_enable = drv_we;
        req_addr0        = drv_addr[0];
        req_addr1        = drv_addr[1];
        req_write_data0  = drv_wd[0];
        req_write_data1  = drv_wd[1];
        @(negedge clk);
        model_cycle();
        cyc++;
    endtask

    task automatic req_once(input int p, input logic [AW-1:0] a, input bit we,
                            input logic [DW-1:0] d);
        bit got;
        got          = 0;
        drv_valid[p] = 1'b1;
        drv_addr[p]  = a;
        drv_we[p]    = we;
        drv_wd[p]    = d;
        for (int i = 0; i < 40; i++) begin
            step();
            if (hs[p]) begin
                got = 1;
                break;
            end
        end
        if (!got) check_eq("hs_timeout", 0, 1);
        drv_valid[p] = 1'b0;
    endtask

    task automatic drain();
        while (cyc < free_cyc) step();
    endtask

    initial begin
        int hs_cyc;
        int grants;
        for (int i = 0; i < 16; i++) begin
            tb_mem[i]  = '0;
            ref_mem[i] = '0;
        end
        drv_valid = 2'b00;
        drv_we    = 2'b00;
        for (int p = 0; p < 2; p++) begin
            drv_addr[p] = '0;
            drv_wd[p]   = '0;
        end
        req_valid        = 2'b00;
        req_write_enable = 2'b00;
        req_addr0        = '0;
        req_addr1        = '0;
        req_write_data0  = '0;
        req_write_data1  = '0;
        model_reset();

        // Reset values
        rst = 1'b1;
        #20;
        check_eq("rst_ready", req_ready, 2'b00);
        check_eq("rst_resp_valid", resp_valid, 2'b00);
        check_eq("rst_resp_data", resp_data, 0);
        check_eq("rst_cache_addr", cache_addr, 0);
        check_eq("rst_cache_we", cache_write_enable, 0);
        check_eq("rst_cache_wdata", cache_write_data, 0);
        #5;
        rst = 1'b0;

        // Write then read on port 1
        req_once(1, 7, 1, 10);
        drain();
        req_once(1, 7, 0, 0);
        drain();
        check_eq("raw_data", resp_data, 10);

        // Port 0 raises valid while port 1 is being served
        req_once(1, 5, 0, 0);
        hs_cyc = cyc - 1;
        step();
        req_once(0, 33, 0, 0);
        check_eq("busy_accept_cycle", cyc - 1, hs_cyc + LAT + 2);
        drain();

        // Randomized traffic
        hs = 2'b00;
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (drv_valid[p] && hs[p]) drv_valid[p] = 1'b0;
                if (!drv_valid[p]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        drv_valid[p] = 1'b1;
                        drv_addr[p]  = $urandom_range(0, 15);
                        drv_we[p]    = 1'($urandom_range(0, 1));
                        drv_wd[p]    = $urandom;
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    drv_valid[p] = 1'b0;
                end
            end
            step();
        end
        drv_valid = 2'b00;
        step();
        drain();

        // Reset during the first access cycle of a write to address 12
        req_once(1, 12, 1, 32'hABCD_1234);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        check_eq("we_before_rst", cache_write_enable, 1);
        #1;
        rst = 1'b1;
        #1;
        check_eq("abort_we", cache_write_enable, 0);
        check_eq("abort_ready", req_ready, 2'b00);
        check_eq("abort_resp_valid", resp_valid, 2'b00);
        check_eq("abort_resp_data", resp_data, 0);
        check_eq("abort_cache_addr", cache_addr, 0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        if (have_txn && t_we) ref_mem[t_addr[3:0]] = t_prior;
        model_reset();
        free_cyc = cyc;
        check_eq("abort_no_write", tb_mem[12], ref_mem[12]);
        repeat (3) step();

        // Continuous conflict: strict alternation starting at port 0
        drv_valid   = 2'b11;
        drv_we      = 2'b00;
        drv_addr[0] = 4;
        drv_addr[1] = 8;
        grants      = 0;
        for (int i = 0; (i < 100) && (grants < 6); i++) begin
            step();
            if (hs != 2'b00) begin
                check_eq("grant_order", hs[1], grants % 2);
                grants++;
            end
        end
        check_eq("conflict_grants", grants, 6);
        drv_valid = 2'b00;
        step();
        drain();
`ifdef CACHE_ARB_STATS_EN
        check_eq("grant_count0", grant_count0, 3);
        check_eq("grant_count1", grant_count1, 3);
        check_eq("conflict_count", conflict_count, st_conf);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
